// File: rtl/systolic_output_collector_if.sv
// systolic_output_collector_if: control, skewed bus and aligned-row handshake signals of the collector
interface systolic_output_collector_if #(
  parameter int COLS      = 32,
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
);
  logic                      start;
  logic [CNT_W-1:0]          num_vectors;
  logic [COLS*WORD_SIZE-1:0] bottom_in_bus;
  logic [COLS*WORD_SIZE-1:0] out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  modport master (
    output start, num_vectors, bottom_in_bus, out_ready,
    input  out_data, out_valid, busy, done, overflow
  );
  modport slave (
    input  start, num_vectors, bottom_in_bus, out_ready,
    output out_data, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: deskews the array's bottom bus into rows and buffers them in a FIFO
module systolic_output_collector #(
  parameter int COLS       = 32,
  parameter int WORD_SIZE  = 16,
  parameter int FIRST_LAT  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  systolic_output_collector_if.slave bus
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FW     = AW + 1;
  localparam int WAIT_W = $clog2(FIRST_LAT + COLS + 1);
  localparam int RW     = COLS * WORD_SIZE;
  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ovf_q, ovf_d;
  logic [RW-1:0]     mem_q [FIFO_DEPTH];
  logic [RW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [RW-1:0]     row;
  logic              push_req, push, pop, full, empty, drop;
  // Column c runs through COLS-c registers (sample stage included) so all words of a vector meet at once
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L = COLS - c;
    logic [WORD_SIZE-1:0] dly_q [L];
    logic [WORD_SIZE-1:0] dly_d [L];
    // Shift the column's delay line by one stage per cycle
    always_comb begin
      dly_d[0] = bus.bottom_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE];
      for (int j = 1; j < L; j++) dly_d[j] = dly_q[j-1];
    end
    // Delay-line registers, cleared on reset
    always_ff @(posedge clk) begin
      if (rst) for (int j = 0; j < L; j++) dly_q[j] <= '0;
      else dly_q <= dly_d;
    end
    assign row[(c+1)*WORD_SIZE-1 -: WORD_SIZE] = dly_q[L-1];
  end
  assign empty    = fill_q == '0;
  assign full     = fill_q == FW'(FIFO_DEPTH);
  assign pop      = !empty && bus.out_ready;
  assign push_req = state_q == CAPTURE;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_q];
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.overflow  = ovf_q;
  // Job sequencing: load counters on start, wait out the array latency, capture, drain, pulse done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_d   = bus.num_vectors;
        ovf_d   = 1'b0;
        wait_d  = WAIT_W'(FIRST_LAT + COLS - 1);
        state_d = bus.num_vectors == '0 ? DONE : WAIT;
      end
      WAIT: begin
        wait_d  = wait_q - 1'b1;
        state_d = wait_q == WAIT_W'(1) ? CAPTURE : WAIT;
      end
      CAPTURE: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CNT_W'(1) ? DRAIN : CAPTURE;
      end
      DRAIN:   state_d = empty ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (drop) ovf_d = 1'b1;
  end
  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = row;
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    fill_d = fill_q + FW'(push) - FW'(pop);
  end
  // Control and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
    end
  end
  // Row storage; contents are only observed while the FIFO is non-empty, so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
